// File: rtl/williams_pkg.sv
// Shared definitions for the Williams SoC RAM-sharing logic.
package williams_pkg;

    localparam int unsigned WILLIAMS_AW = 16;
    localparam int unsigned WILLIAMS_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ram_share_arbiter.sv
// Shares the work/video RAM port between the CPU (absolute priority, combinational
// path) and one auxiliary requester that gets short, abortable accesses.
module ram_share_arbiter
    import williams_pkg::*;
#(
    parameter int unsigned AW      = WILLIAMS_AW,
    parameter int unsigned DW      = WILLIAMS_DW,
    parameter int unsigned HOLD    = 2,
    parameter int unsigned MAXWAIT = 255
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_di,
    input  logic          cpu_we_n,
    input  logic          cpu_cs_n,
    input  logic          cpu_lb_n,
    input  logic          cpu_ub_n,
    output logic [DW-1:0] cpu_do,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_din,
    input  logic          aux_window,
    output logic          aux_ack,
    output logic [DW-1:0] aux_dout,
    output logic          aux_busy,
    output logic          aux_starved,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_di,
    output logic          ram_we,
    output logic          ram_enl,
    output logic          ram_enh,
    input  logic [DW-1:0] ram_do
);

    localparam int unsigned HW     = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int unsigned SW_MIN = $clog2(MAXWAIT + 1);
    localparam int unsigned SW     = (SW_MIN > 8) ? SW_MIN : 8;

    arb_state_e    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          lat_we_q, lat_we_d;
    logic [AW-1:0] lat_addr_q, lat_addr_d;
    logic [DW-1:0] lat_din_q, lat_din_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starved_q, starved_d;

    logic grant;
    logic blocked;
    logic abort;

    assign grant   = (state_q == IDLE) && aux_req && aux_window && cpu_cs_n;
    assign blocked = (state_q == IDLE) && aux_req && aux_window && !cpu_cs_n;
    assign abort   = ((state_q == SETUP) || (state_q == ACCESS)) && !cpu_cs_n;

    // Next-state, latch, capture and starvation bookkeeping.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_din_d    = lat_din_q;
        dout_d       = dout_q;
        ack_d        = 1'b0;
        starve_cnt_d = starve_cnt_q;
        starved_d    = starved_q;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d    = SETUP;
                    lat_we_d   = aux_we;
                    lat_addr_d = aux_addr;
                    lat_din_d  = aux_din;
                end
            end
            SETUP: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                    hold_d  = HW'(HOLD - 1);
                end
            end
            ACCESS: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hold_q == '0) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                    if (!lat_we_q) begin
                        dout_d = ram_do;
                    end
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);

        // Saturating count of denied cycles; a completed access clears everything.
        if (ack_d) begin
            starve_cnt_d = '0;
            starved_d    = 1'b0;
        end else begin
            if ((blocked || abort) && (starve_cnt_q != {SW{1'b1}})) begin
                starve_cnt_d = starve_cnt_q + SW'(1);
            end
            if (starve_cnt_d >= SW'(MAXWAIT)) begin
                starved_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_din_q    <= '0;
            dout_q       <= '0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            starve_cnt_q <= '0;
            starved_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            lat_we_q     <= lat_we_d;
            lat_addr_q   <= lat_addr_d;
            lat_din_q    <= lat_din_d;
            dout_q       <= dout_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            starve_cnt_q <= starve_cnt_d;
            starved_q    <= starved_d;
        end
    end

    // RAM port mux: the CPU wins in any cycle it selects RAM, with no added latency.
    always_comb begin
        ram_addr = lat_addr_q;
        ram_di   = lat_din_q;
        ram_we   = 1'b0;
        ram_enl  = 1'b0;
        ram_enh  = 1'b0;
        if (!cpu_cs_n) begin
            ram_addr = cpu_addr;
            ram_di   = cpu_di;
            ram_we   = !cpu_we_n;
            ram_enl  = !cpu_lb_n;
            ram_enh  = !cpu_ub_n;
        end else begin
            case (state_q)
                SETUP: begin
                    ram_enl = 1'b1;
                    ram_enh = 1'b1;
                end
                ACCESS: begin
                    ram_we  = lat_we_q;
                    ram_enl = 1'b1;
                    ram_enh = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign cpu_do      = ram_do;
    assign aux_ack     = ack_q;
    assign aux_dout    = dout_q;
    assign aux_busy    = busy_q;
    assign aux_starved = starved_q;

endmodule

// File: tb/tb_ram_share_arbiter.sv
// Bench for ram_share_arbiter: directed scenarios plus random traffic against a
// cycle-phase reference model and a negedge-clocked RAM.
module tb_ram_share_arbiter;

    localparam int unsigned AW      = 16;
    localparam int unsigned DW      = 8;
    localparam int          HOLD    = 2;
    localparam int          MAXWAIT = 255;
    localparam int          P_DONE  = HOLD + 2;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_di;
    logic          cpu_we_n, cpu_cs_n, cpu_lb_n, cpu_ub_n;
    logic [DW-1:0] cpu_do;
    logic          aux_req, aux_we, aux_window;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_din;
    logic          aux_ack, aux_busy, aux_starved;
    logic [DW-1:0] aux_dout;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic          ram_we, ram_enl, ram_enh;
    logic [DW-1:0] ram_do = '0;

    logic [7:0] mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: m_p counts cycles since the grant edge (0 = no access open).
    int         m_p;
    logic       m_we;
    logic [15:0] m_addr;
    logic [7:0] m_din, m_dout;
    int         m_cnt;
    logic       m_starved;

    ram_share_arbiter #(
        .AW(AW), .DW(DW), .HOLD(HOLD), .MAXWAIT(MAXWAIT)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_we_n(cpu_we_n),
        .cpu_cs_n(cpu_cs_n), .cpu_lb_n(cpu_lb_n), .cpu_ub_n(cpu_ub_n),
        .cpu_do(cpu_do),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_din(aux_din),
        .aux_window(aux_window), .aux_ack(aux_ack), .aux_dout(aux_dout),
        .aux_busy(aux_busy), .aux_starved(aux_starved),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we),
        .ram_enl(ram_enl), .ram_enh(ram_enh), .ram_do(ram_do)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM clocked on the falling edge, as williams_ram is.
    always @(negedge clk_sys) begin
        if (ram_we && ram_enl) mem[ram_addr] = ram_di;
        ram_do <= mem[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_p = 0; m_we = 1'b0; m_addr = '0; m_din = '0; m_dout = '0;
        m_cnt = 0; m_starved = 1'b0;
    endtask

    task automatic bump();
        if (m_cnt < 255) m_cnt++;
        if (m_cnt >= MAXWAIT) m_starved = 1'b1;
    endtask

    task automatic model_step();
        if (m_p == 0) begin
            if (aux_req && aux_window && cpu_cs_n) begin
                m_p = 1; m_we = aux_we; m_addr = aux_addr; m_din = aux_din;
            end else if (aux_req && aux_window) begin
                bump();
            end
        end else if (m_p <= HOLD + 1 && !cpu_cs_n) begin
            m_p = 0;
            bump();
        end else if (m_p == HOLD + 1) begin
            if (!m_we) m_dout = ram_do;
            m_p = P_DONE; m_cnt = 0; m_starved = 1'b0;
        end else if (m_p == P_DONE) begin
            m_p = 0;
        end else begin
            m_p++;
        end
    endtask

    task automatic compare_outputs();
        logic [15:0] ea;
        logic [7:0]  ed;
        logic        ewe, el, eh, chk_di;
        ea = m_addr; ed = m_din; ewe = 1'b0; el = 1'b0; eh = 1'b0; chk_di = 1'b0;
        if (!cpu_cs_n) begin
            ea = cpu_addr; ed = cpu_di; ewe = !cpu_we_n; el = !cpu_lb_n; eh = !cpu_ub_n;
            chk_di = 1'b1;
        end else if (m_p == 1) begin
            el = 1'b1; eh = 1'b1;
        end else if (m_p >= 2 && m_p <= HOLD + 1) begin
            ewe = m_we; el = 1'b1; eh = 1'b1; chk_di = 1'b1;
        end
        check_eq("ram_addr", 32'(ram_addr), 32'(ea));
        if (chk_di) check_eq("ram_di", 32'(ram_di), 32'(ed));
        check_eq("ram_we", 32'(ram_we), 32'(ewe));
        check_eq("ram_enl", 32'(ram_enl), 32'(el));
        check_eq("ram_enh", 32'(ram_enh), 32'(eh));
        check_eq("cpu_do", 32'(cpu_do), 32'(ram_do));
        check_eq("aux_ack", 32'(aux_ack), 32'(m_p == P_DONE));
        check_eq("aux_busy", 32'(aux_busy), 32'(m_p != 0));
        check_eq("aux_starved", 32'(aux_starved), 32'(m_starved));
        check_eq("aux_dout", 32'(aux_dout), 32'(m_dout));
    endtask

    // Called just after a rising edge with inputs already applied for this cycle.
    task automatic tick();
        #1;
        compare_outputs();
        @(negedge clk_sys);
        #1;
        model_step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic aux_start(input logic we, input logic [15:0] a, input logic [7:0] d);
        aux_req = 1'b1; aux_we = we; aux_addr = a; aux_din = d;
    endtask

    initial begin
        int ack_at, busy_n, wcnt, acks, found;
        logic [15:0] addrs [8];

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) addrs[i] = 16'h9800 + 16'(i);
        reset_n = 1'b0;
        cpu_addr = '0; cpu_di = '0; cpu_we_n = 1'b1; cpu_cs_n = 1'b1;
        cpu_lb_n = 1'b1; cpu_ub_n = 1'b1;
        aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_din = '0; aux_window = 1'b1;
        model_reset();

        repeat (3) @(posedge clk_sys);
        #1;
        check_eq("rst_ack", 32'(aux_ack), 32'd0);
        check_eq("rst_busy", 32'(aux_busy), 32'd0);
        check_eq("rst_dout", 32'(aux_dout), 32'd0);
        check_eq("rst_ram_we", 32'(ram_we), 32'd0);
        check_eq("rst_ram_en", 32'({ram_enl, ram_enh}), 32'd0);
        reset_n = 1'b1;

        // Uncontested read.
        mem[16'h9800] = 8'h5A;
        aux_start(1'b0, 16'h9800, 8'h00);
        ack_at = 0; busy_n = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            busy_n += int'(aux_busy);
            if (aux_ack) begin ack_at = k; aux_req = 1'b0; end
        end
        check_eq("rd_ack_lat", 32'(ack_at), 32'd4);
        check_eq("rd_busy_cycles", 32'(busy_n), 32'd4);
        check_eq("rd_data", 32'(aux_dout), 32'h5A);

        // Write then read back.
        aux_start(1'b1, 16'hCC00, 8'h3C);
        wcnt = 0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (ram_we && ram_addr == 16'hCC00 && ram_di == 8'h3C) wcnt++;
            tick();
            if (aux_ack) aux_req = 1'b0;
        end
        check_eq("wr_we_cycles", 32'(wcnt), 32'd2);
        check_eq("wr_mem", 32'(mem[16'hCC00]), 32'h3C);
        aux_start(1'b0, 16'hCC00, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (aux_ack) aux_req = 1'b0;
        end
        check_eq("wr_readback", 32'(aux_dout), 32'h3C);

        // CPU abort in the first ACCESS cycle, then automatic retry.
        aux_start(1'b0, 16'h9801, 8'h00);
        tick();
        tick();
        cpu_cs_n = 1'b0; cpu_addr = 16'h1234; cpu_we_n = 1'b1; cpu_lb_n = 1'b0; cpu_ub_n = 1'b0;
        #1;
        check_eq("abort_cpu_addr", 32'(ram_addr), 32'h1234);
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            acks += int'(aux_ack);
        end
        check_eq("abort_no_ack", 32'(acks), 32'd0);
        cpu_cs_n = 1'b1;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (aux_ack) begin found = 1; aux_req = 1'b0; end
        end
        check_eq("abort_retry_ack", 32'(found), 32'd1);
        check_eq("abort_data", 32'(aux_dout), 32'(mem[16'h9801]));
        check_eq("abort_starved", 32'(aux_starved), 32'd0);

        // Closed window: no grant, no starvation counting.
        aux_window = 1'b0;
        aux_start(1'b0, 16'h9802, 8'h00);
        busy_n = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            busy_n += int'(aux_busy);
        end
        check_eq("win_no_grant", 32'(busy_n), 32'd0);
        check_eq("win_not_starved", 32'(aux_starved), 32'd0);
        // Open window but CPU hogs the port: starved after MAXWAIT blocked cycles.
        aux_window = 1'b1; cpu_cs_n = 1'b0; cpu_addr = 16'h0042;
        for (int k = 0; k < MAXWAIT - 1; k++) tick();
        check_eq("starve_before", 32'(aux_starved), 32'd0);
        tick();
        check_eq("starve_at_max", 32'(aux_starved), 32'd1);
        repeat (5) tick();
        check_eq("starve_sticky", 32'(aux_starved), 32'd1);
        cpu_cs_n = 1'b1;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (aux_ack) begin found = 1; aux_req = 1'b0; end
        end
        check_eq("starve_grant_ack", 32'(found), 32'd1);
        check_eq("starve_cleared", 32'(aux_starved), 32'd0);

        // Request held across ack: one IDLE cycle then a new access.
        aux_start(1'b0, 16'h9803, 8'h00);
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            tick();
            if (aux_ack) found = 1;
        end
        check_eq("held_ack", 32'(found), 32'd1);
        tick();
        check_eq("held_idle_gap", 32'(aux_busy), 32'd0);
        tick();
        check_eq("held_regrant", 32'(aux_busy), 32'd1);
        aux_req = 1'b0;
        repeat (6) tick();

        // Reset in the middle of ACCESS.
        aux_start(1'b0, 16'h9804, 8'h00);
        tick();
        tick();
        aux_req = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("mrst_busy", 32'(aux_busy), 32'd0);
        check_eq("mrst_ack", 32'(aux_ack), 32'd0);
        check_eq("mrst_dout", 32'(aux_dout), 32'd0);
        check_eq("mrst_ram_we", 32'(ram_we), 32'd0);
        check_eq("mrst_ram_en", 32'({ram_enl, ram_enh}), 32'd0);
        check_eq("mrst_ram_addr", 32'(ram_addr), 32'd0);
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        cpu_cs_n = 1'b0; cpu_addr = 16'h4321; cpu_di = 8'h77; cpu_we_n = 1'b0;
        cpu_lb_n = 1'b0; cpu_ub_n = 1'b1;
        #1;
        check_eq("mrst_cpu_addr", 32'(ram_addr), 32'h4321);
        check_eq("mrst_cpu_we", 32'(ram_we), 32'd1);
        check_eq("mrst_cpu_lanes", 32'({ram_enl, ram_enh}), 32'b10);
        tick();
        cpu_cs_n = 1'b1; cpu_we_n = 1'b1;
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cpu_cs_n   = ($urandom_range(0, 99) < 25) ? 1'b0 : 1'b1;
            cpu_addr   = ($urandom_range(0, 1) == 0) ? addrs[$urandom_range(0, 7)] : 16'($urandom);
            cpu_di     = 8'($urandom);
            cpu_we_n   = 1'($urandom);
            cpu_lb_n   = 1'($urandom);
            cpu_ub_n   = 1'($urandom);
            aux_window = ($urandom_range(0, 9) != 0);
            if (m_p == P_DONE) aux_req = ($urandom_range(0, 3) == 0);
            else if (!aux_req) aux_req = ($urandom_range(0, 2) == 0);
            aux_we   = 1'($urandom);
            aux_addr = addrs[$urandom_range(0, 7)];
            aux_din  = 8'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
